// File: rtl/mix_columns_sequencer.sv
// Column-serial AES MixColumns engine: one shared 32-bit column mixer walks the four
// columns of a buffered 128-bit state, forward or inverse per transaction.
module mix_columns_sequencer (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  input  logic         flush,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         mode_q, mode_d;
  logic [127:0] buf_q, buf_d;

  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Column select mux feeding the single mixer instance.
  always_comb begin
    col_in = buf_q[127:96];
    unique case (col_q)
      2'd0: col_in = buf_q[127:96];
      2'd1: col_in = buf_q[95:64];
      2'd2: col_in = buf_q[63:32];
      2'd3: col_in = buf_q[31:0];
      default: col_in = buf_q[127:96];
    endcase
  end

  // Shared column mixer; inverse coefficients built from x2/x4/x8 multiples.
  always_comb begin
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = col_in[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (mode_q) begin
      col_out = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                 m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                 m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                 m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    end else begin
      col_out = {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                 a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                 a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                 x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          buf_d   = in_state;
          mode_d  = in_inverse;
          col_d   = 2'd0;
          state_d = StMix;
        end
      end
      StMix: begin
        unique case (col_q)
          2'd0: buf_d[127:96] = col_out;
          2'd1: buf_d[95:64]  = col_out;
          2'd2: buf_d[63:32]  = col_out;
          2'd3: buf_d[31:0]   = col_out;
          default: buf_d = buf_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Flush aborts without touching the buffer or mode.
    if (flush) begin
      state_d = StIdle;
      col_d   = 2'd0;
      buf_d   = buf_q;
      mode_d  = mode_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      col_q   <= 2'd0;
      mode_q  <= 1'b0;
      buf_q   <= 128'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_state = buf_q;

endmodule
